// File: rtl/trng_pkg.sv
// Shared types and constants for the ring-oscillator TRNG sequencer.
package trng_pkg;

    // Depth of the capture/sync pipeline inside the TRNG core; warm-up must cover it.
    localparam int TRNG_PIPE_STAGES = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        COLLECT = 3'd2,
        FULL    = 3'd3,
        ERROR   = 3'd4
    } trng_state_e;

endpackage

// File: rtl/trng_health_rep.sv
// Repetition-count health test: flags REP_LIMIT consecutive identical samples.
module trng_health_rep #(
    parameter int REP_LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_valid,
    input  logic sample,
    input  logic clear,
    output logic fail
);

    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
    localparam logic [REP_W-1:0] REP_TRIP = REP_W'(REP_LIMIT - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             last_q, last_d;
    logic             repeat_bit;

    // rep == 0 means no sample seen since the last clear, so last_q is not meaningful.
    assign repeat_bit = (rep_q != '0) && (sample == last_q);
    assign fail       = sample_valid && repeat_bit && (rep_q == REP_TRIP);

    always_comb begin
        rep_d  = rep_q;
        last_d = last_q;
        if (clear) begin
            rep_d  = '0;
            last_d = 1'b0;
        end else if (sample_valid) begin
            last_d = sample;
            if (!repeat_bit) begin
                rep_d = REP_W'(1);
            end else if (rep_q != REP_MAX) begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_q  <= '0;
            last_q <= 1'b0;
        end else begin
            rep_q  <= rep_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: oscillator gating, warm-up, divided sampling, word packing,
// repetition health test and a valid/ready word output.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int WARMUP_CYCLES = 64,
    parameter int SAMPLE_DIV    = 4,
    parameter int REP_LIMIT     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  trng_en,
    input  logic                  trng_out,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  rready,
    output logic                  error,
    output logic [2:0]            state_dbg
);

    localparam int WCNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BCNT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(WORD_WIDTH - 1);

    if (WARMUP_CYCLES < TRNG_PIPE_STAGES) begin : g_bad_warmup
        $error("trng_ctrl: WARMUP_CYCLES must be >= %0d", TRNG_PIPE_STAGES);
    end
    if (SAMPLE_DIV < 1) begin : g_bad_div
        $error("trng_ctrl: SAMPLE_DIV must be >= 1");
    end
    if (REP_LIMIT < 2) begin : g_bad_rep
        $error("trng_ctrl: REP_LIMIT must be >= 2");
    end

    trng_state_e           state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  error_q, error_d;
    logic                  trng_en_q, trng_en_d;

    logic sample_take;
    logic rep_clear;
    logic rep_fail;
    logic handshake;

    // Handshake: a word moves when rvalid & rready are both high at a clk edge;
    // rdata is held stable while rvalid & !rready, and rvalid drops the cycle after
    // a transfer unless a fresh word is loaded at that same edge.
    assign handshake   = rvalid_q && rready;
    assign sample_take = enable && (state_q == COLLECT) && (div_q == DIV_LAST);
    // Rep history is dropped in every state that leads into WARMUP.
    assign rep_clear   = !enable || (state_q == IDLE) || (state_q == FULL);

    trng_health_rep #(
        .REP_LIMIT (REP_LIMIT)
    ) u_health_rep (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_take),
        .sample       (trng_out),
        .clear        (rep_clear),
        .fail         (rep_fail)
    );

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        div_d    = div_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        error_d  = error_q;

        if (handshake) begin
            rvalid_d = 1'b0;
        end

        if (!enable) begin
            state_d  = IDLE;
            wcnt_d   = '0;
            div_d    = '0;
            bcnt_d   = '0;
            shift_d  = '0;
            rvalid_d = 1'b0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WARMUP;
                    wcnt_d  = '0;
                end
                WARMUP: begin
                    if (wcnt_q == WARM_LAST) begin
                        state_d = COLLECT;
                        div_d   = '0;
                        bcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
                COLLECT: begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                    if (sample_take) begin
                        shift_d = {shift_q[WORD_WIDTH-2:0], trng_out};
                        bcnt_d  = bcnt_q + 1'b1;
                        if (rep_fail) begin
                            state_d  = ERROR;
                            error_d  = 1'b1;
                            rvalid_d = 1'b0;
                        end else if (bcnt_q == BIT_LAST) begin
                            if (!rvalid_q || handshake) begin
                                rdata_d  = shift_d;
                                rvalid_d = 1'b1;
                                bcnt_d   = '0;
                            end else begin
                                state_d = FULL;
                            end
                        end
                    end
                end
                FULL: begin
                    if (handshake) begin
                        rdata_d  = shift_q;
                        rvalid_d = 1'b1;
                        bcnt_d   = '0;
                        wcnt_d   = '0;
                        state_d  = WARMUP;
                    end
                end
                ERROR: begin
                    error_d  = 1'b1;
                    rvalid_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        trng_en_d = (state_d == WARMUP) || (state_d == COLLECT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            div_q     <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            error_q   <= 1'b0;
            trng_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            div_q     <= div_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            error_q   <= error_d;
            trng_en_q <= trng_en_d;
        end
    end

    assign trng_en   = trng_en_q;
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign error     = error_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl: directed scenarios plus a randomized run, all checked each
// cycle against a behavioural model of the sequencer.
module tb_trng_ctrl;

    localparam int WORD_WIDTH    = 8;
    localparam int WARMUP_CYCLES = 8;
    localparam int SAMPLE_DIV    = 2;
    localparam int REP_LIMIT     = 4;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_COLL = 2;
    localparam int M_FULL = 3;
    localparam int M_ERR  = 4;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  enable = 1'b0;
    logic                  trng_out = 1'b0;
    logic                  rready = 1'b0;
    logic                  trng_en;
    logic [WORD_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  error;
    logic [2:0]            state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    trng_ctrl #(
        .WORD_WIDTH    (WORD_WIDTH),
        .WARMUP_CYCLES (WARMUP_CYCLES),
        .SAMPLE_DIV    (SAMPLE_DIV),
        .REP_LIMIT     (REP_LIMIT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .trng_en   (trng_en),
        .trng_out  (trng_out),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .error     (error),
        .state_dbg (state_dbg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                    m_mode  = M_IDLE;
    int                    m_warm  = 0;
    int                    m_coll  = 0;
    logic                  m_rvalid = 1'b0;
    logic                  m_error  = 1'b0;
    logic [WORD_WIDTH-1:0] m_rdata  = '0;
    bit                    m_bits[$];
    bit                    m_hist[$];
    logic [WORD_WIDTH-1:0] exp_q[$];

    function automatic logic [WORD_WIDTH-1:0] pack_bits();
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        foreach (m_bits[i]) w = (w << 1) | WORD_WIDTH'(m_bits[i]);
        return w;
    endfunction

    function automatic int trailing_run();
        int n;
        n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != m_hist[m_hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_warm   = 0;
        m_coll   = 0;
        m_rvalid = 1'b0;
        m_error  = 1'b0;
        m_rdata  = '0;
        m_bits.delete();
        m_hist.delete();
        exp_q.delete();
    endtask

    task automatic load_word();
        m_rdata  = pack_bits();
        m_rvalid = 1'b1;
        m_bits.delete();
        exp_q.push_back(m_rdata);
    endtask

    task automatic model_step(input logic en, input logic b, input logic rr);
        bit hs;
        hs = m_rvalid && rr;
        if (!en) begin
            m_mode   = M_IDLE;
            m_rvalid = 1'b0;
            m_error  = 1'b0;
            m_bits.delete();
            m_hist.delete();
            exp_q.delete();
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_mode = M_WARM;
                m_warm = 0;
                m_hist.delete();
            end
            M_WARM: begin
                if (hs) m_rvalid = 1'b0;
                m_warm++;
                if (m_warm == WARMUP_CYCLES) begin
                    m_mode = M_COLL;
                    m_coll = 0;
                end
            end
            M_COLL: begin
                m_coll++;
                if (m_coll % SAMPLE_DIV == 0) begin
                    m_bits.push_back(b);
                    m_hist.push_back(b);
                    if (m_hist.size() > REP_LIMIT) void'(m_hist.pop_front());
                    if (trailing_run() >= REP_LIMIT) begin
                        m_mode   = M_ERR;
                        m_error  = 1'b1;
                        m_rvalid = 1'b0;
                        exp_q.delete();
                        return;
                    end
                    if (m_bits.size() == WORD_WIDTH) begin
                        if (!m_rvalid || hs) begin
                            load_word();
                            return;
                        end
                        m_mode = M_FULL;
                    end
                end
                if (hs) m_rvalid = 1'b0;
            end
            M_FULL: begin
                if (hs) begin
                    load_word();
                    m_mode = M_WARM;
                    m_warm = 0;
                    m_hist.delete();
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step(enable, trng_out, rready);
    end

    // ---------------- compare process / scoreboard ----------------
    always @(negedge clk) begin
        chk("trng_en", trng_en, (m_mode == M_WARM || m_mode == M_COLL));
        chk("rvalid", rvalid, m_rvalid);
        chk("error", error, m_error);
        if (m_rvalid) chk("rdata", rdata, m_rdata);
        if (rvalid && rready) begin
            if (exp_q.size() > 0) begin
                chk("sb_word", rdata, exp_q.pop_front());
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_word: transfer of %0h with no expected word at %0t", rdata, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit stim_q[$];
    bit prev_bit = 1'b0;

    function automatic bit sample_due();
        return enable && (m_mode == M_COLL) && (((m_coll + 1) % SAMPLE_DIV) == 0);
    endfunction

    task automatic push_word(input logic [WORD_WIDTH-1:0] w);
        for (int i = WORD_WIDTH - 1; i >= 0; i--) stim_q.push_back(w[i]);
    endtask

    task automatic tick();
        if (sample_due() && stim_q.size() > 0) trng_out = stim_q.pop_front();
        else trng_out = prev_bit ^ ($urandom_range(0, 3) != 0);
        prev_bit = trng_out;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        rready  = 1'b0;
        stim_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_trng_en", trng_en, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_error", error, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1: alternating samples, consumer always ready
        do_reset();
        push_word(8'hAA);
        enable = 1'b1;
        rready = 1'b1;
        for (int e = 0; e <= 24; e++) begin
            tick();
            if (e == 0) chk("t1_trng_en_c1", trng_en, 1);
            if (e == 23) chk("t1_rvalid_c24", rvalid, 0);
            if (e == 24) begin
                chk("t1_rvalid_c25", rvalid, 1);
                chk("t1_rdata_c25", rdata, 8'hAA);
                chk("t1_error", error, 0);
            end
        end

        // 2: consumer stalls -> FULL, then one transfer
        do_reset();
        push_word(8'hAA);
        push_word(8'hCC);
        enable = 1'b1;
        for (int e = 0; e <= 43; e++) begin
            tick();
            if (e == 24) chk("t2_first_word", rdata, 8'hAA);
            if (e == 40 || e == 43) begin
                chk("t2_full_trng_en", trng_en, 0);
                chk("t2_full_rvalid", rvalid, 1);
                chk("t2_full_rdata", rdata, 8'hAA);
            end
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("t2_second_word", rdata, 8'hCC);
        chk("t2_second_rvalid", rvalid, 1);
        chk("t2_rewarm_trng_en", trng_en, 1);
        for (int e = 0; e < 30; e++) tick();

        // 3: repetition failure, cleared by enable=0
        do_reset();
        for (int i = 0; i < REP_LIMIT; i++) stim_q.push_back(1'b1);
        enable = 1'b1;
        rready = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            if (e == 15) chk("t3_error_before", error, 0);
            if (e == 16) begin
                chk("t3_error", error, 1);
                chk("t3_trng_en", trng_en, 0);
                chk("t3_rvalid", rvalid, 0);
            end
        end
        enable = 1'b0;
        tick();
        chk("t3_error_cleared", error, 0);
        chk("t3_idle_trng_en", trng_en, 0);

        // 4: completion coincides with a transfer; then async reset while active
        do_reset();
        push_word(8'hAA);
        push_word(8'h96);
        enable = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            if (e == 40) rready = 1'b1;
            tick();
            if (e == 39) chk("t4_old_word", rdata, 8'hAA);
            if (e == 40) begin
                chk("t4_no_gap_rvalid", rvalid, 1);
                chk("t4_new_word", rdata, 8'h96);
            end
        end
        rready = 1'b0;
        chk("t6_active_trng_en", trng_en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_trng_en", trng_en, 0);
        chk("t6_async_rvalid", rvalid, 0);

        // 5: enable dropped at bit count 5, then restart
        do_reset();
        stim_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        push_word(8'h5A);
        enable = 1'b1;
        rready = 1'b1;
        for (int e = 0; e <= 44; e++) begin
            if (e == 19) enable = 1'b0;
            if (e == 20) enable = 1'b1;
            tick();
            if (e == 19) chk("t5_stop_trng_en", trng_en, 0);
            if (e == 43) chk("t5_rvalid_early", rvalid, 0);
            if (e == 44) begin
                chk("t5_rvalid", rvalid, 1);
                chk("t5_word", rdata, 8'h5A);
            end
        end

        // 6: async reset while in the error state
        do_reset();
        for (int i = 0; i < REP_LIMIT; i++) stim_q.push_back(1'b0);
        enable = 1'b1;
        for (int e = 0; e <= 18; e++) tick();
        chk("t6_err_set", error, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_error", error, 0);
        chk("t6_async_trng_en_err", trng_en, 0);

        // randomized run
        do_reset();
        begin
            int rr_level;
            rr_level = 5;
            for (int c = 0; c < 4000; c++) begin
                if (c % 200 == 0) rr_level = $urandom_range(0, 10);
                enable = ($urandom_range(0, 199) != 0);
                rready = ($urandom_range(0, 9) < rr_level);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
